// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between two requesters, a clear controller and a register file.
// Carries the two valid/ready request channels, the clear start/busy/done handshake
// and the registered write port (WE3/A3/WD3). No logic lives here.
//
// Ports (signals):
//   REQ0_VALID/ADDR/DATA, REQ0_READY  requester 0 write channel
//   REQ1_VALID/ADDR/DATA, REQ1_READY  requester 1 write channel
//   CLR_START, BUSY, CLR_DONE         clear sequence control/status
//   WE3, A3, WD3                      register file write port
interface regfile_write_arbiter_if;
  logic        REQ0_VALID;
  logic [4:0]  REQ0_ADDR;
  logic [31:0] REQ0_DATA;
  logic        REQ0_READY;
  logic        REQ1_VALID;
  logic [4:0]  REQ1_ADDR;
  logic [31:0] REQ1_DATA;
  logic        REQ1_READY;
  logic        CLR_START;
  logic        BUSY;
  logic        CLR_DONE;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  // Requester / controller side.
  modport master (
    output REQ0_VALID, REQ0_ADDR, REQ0_DATA,
    output REQ1_VALID, REQ1_ADDR, REQ1_DATA,
    output CLR_START,
    input  REQ0_READY, REQ1_READY, BUSY, CLR_DONE, WE3, A3, WD3
  );

  // Arbiter side.
  modport slave (
    input  REQ0_VALID, REQ0_ADDR, REQ0_DATA,
    input  REQ1_VALID, REQ1_ADDR, REQ1_DATA,
    input  CLR_START,
    output REQ0_READY, REQ1_READY, BUSY, CLR_DONE, WE3, A3, WD3
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: arbitrates two register-file write requesters (round-robin) and a clear
//   sequence that zeroes registers 0..CLR_COUNT-1 onto a single registered write port.
// Latency: 1 cycle from handshake (or clear start) to WE3/A3/WD3; backpressure via
//   combinational READY, low during clear, CLR_START cycles and reset.
//
// Ports:
//   CLK    rising-edge clock
//   RESET  synchronous active-high reset
//   bus    regfile_write_arbiter_if.slave: request channels, clear control, write port
module regfile_write_arbiter #(
  parameter int CLR_COUNT = 8   // registers zeroed by a clear, 1..32
) (
  input logic                     CLK,
  input logic                     RESET,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [4:0] LAST_ADDR = 5'(CLR_COUNT - 1);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;      // requester favoured on a tie
  logic [4:0]  cnt_q, cnt_d;        // next clear address to emit while in CLEAR
  logic        we3_q, we3_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd3_q, wd3_d;
  logic        busy_q, busy_d;      // a clear write is on the port this cycle
  logic        done_q, done_d;

  logic accept_ok;
  logic gnt0;
  logic gnt1;

  // Grants are mutually exclusive: on a tie only the PRIO side wins.
  always_comb begin
    accept_ok = !RESET && (state_q == IDLE) && !bus.CLR_START;
    gnt0      = accept_ok && bus.REQ0_VALID && (!bus.REQ1_VALID || !prio_q);
    gnt1      = accept_ok && bus.REQ1_VALID && (!bus.REQ0_VALID ||  prio_q);
  end

  assign bus.REQ0_READY = gnt0;
  assign bus.REQ1_READY = gnt1;
  assign bus.WE3        = we3_q;
  assign bus.A3         = a3_q;
  assign bus.WD3        = wd3_q;
  assign bus.BUSY       = busy_q;
  assign bus.CLR_DONE   = done_q;

  // FSM leaves CLEAR on the edge that launches the final clear write, so the
  // port is free for a request during the cycle that write is presented. BUSY
  // follows the write port rather than the state, which keeps CLR_START
  // ignored in that last cycle as well.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    we3_d   = 1'b0;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.CLR_START && !busy_q) begin
          we3_d  = 1'b1;
          a3_d   = 5'd0;
          wd3_d  = 32'd0;
          busy_d = 1'b1;
          if (LAST_ADDR == 5'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = CLEAR;
            cnt_d   = 5'd1;
          end
        end else if (gnt0) begin
          we3_d  = 1'b1;
          a3_d   = bus.REQ0_ADDR;
          wd3_d  = bus.REQ0_DATA;
          prio_d = 1'b1;
        end else if (gnt1) begin
          we3_d  = 1'b1;
          a3_d   = bus.REQ1_ADDR;
          wd3_d  = bus.REQ1_DATA;
          prio_d = 1'b0;
        end
      end

      CLEAR: begin
        we3_d  = 1'b1;
        a3_d   = cnt_q;
        wd3_d  = 32'd0;
        busy_d = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= 5'd0;
      we3_q   <= 1'b0;
      a3_q    <= 5'd0;
      wd3_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      we3_q   <= we3_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with CLR_COUNT=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Summary line reports passed/total checks.
module tb_regfile_write_arbiter;

  logic CLK;
  logic RESET;
  int   n_pass;
  int   n_total;

  regfile_write_arbiter_if bus();

  regfile_write_arbiter #(.CLR_COUNT(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.REQ0_VALID = 1'b0;
    bus.REQ0_ADDR  = 5'd0;
    bus.REQ0_DATA  = 32'd0;
    bus.REQ1_VALID = 1'b0;
    bus.REQ1_ADDR  = 5'd0;
    bus.REQ1_DATA  = 32'd0;
    bus.CLR_START  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b1;
    bus.REQ0_VALID = 1'b1;
    tick();
    tick();
    n_total++; if (bus.WE3 !== 1'b0) $display("FAIL reset_we3: got %b exp 0", bus.WE3); else n_pass++;
    n_total++; if (bus.A3 !== 5'd0) $display("FAIL reset_a3: got %0d exp 0", bus.A3); else n_pass++;
    n_total++; if (bus.WD3 !== 32'd0) $display("FAIL reset_wd3: got %h exp 0", bus.WD3); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy: got %b exp 0", bus.BUSY); else n_pass++;
    n_total++; if (bus.CLR_DONE !== 1'b0) $display("FAIL reset_done: got %b exp 0", bus.CLR_DONE); else n_pass++;
    n_total++; if (bus.REQ0_READY !== 1'b0) $display("FAIL reset_ready0: got %b exp 0", bus.REQ0_READY); else n_pass++;
    bus.REQ0_VALID = 1'b0;
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_single_req0();
    bus.REQ0_VALID = 1'b1;
    bus.REQ0_ADDR  = 5'd5;
    bus.REQ0_DATA  = 32'hDEADBEEF;
    #1;
    n_total++; if (bus.REQ0_READY !== 1'b1) $display("FAIL single_ready0: got %b exp 1", bus.REQ0_READY); else n_pass++;
    n_total++; if (bus.REQ1_READY !== 1'b0) $display("FAIL single_ready1: got %b exp 0", bus.REQ1_READY); else n_pass++;
    tick();
    bus.REQ0_VALID = 1'b0;
    n_total++; if (bus.WE3 !== 1'b1) $display("FAIL single_we3: got %b exp 1", bus.WE3); else n_pass++;
    n_total++; if (bus.A3 !== 5'd5) $display("FAIL single_a3: got %0d exp 5", bus.A3); else n_pass++;
    n_total++; if (bus.WD3 !== 32'hDEADBEEF) $display("FAIL single_wd3: got %h exp deadbeef", bus.WD3); else n_pass++;
    tick();
    n_total++; if (bus.WE3 !== 1'b0) $display("FAIL single_we3_off: got %b exp 0", bus.WE3); else n_pass++;
    n_total++; if (bus.A3 !== 5'd5) $display("FAIL single_a3_hold: got %0d exp 5", bus.A3); else n_pass++;
    n_total++; if (bus.WD3 !== 32'hDEADBEEF) $display("FAIL single_wd3_hold: got %h exp deadbeef", bus.WD3); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    bus.REQ0_VALID = 1'b1;
    bus.REQ0_ADDR  = 5'd1;
    bus.REQ0_DATA  = 32'h11;
    bus.REQ1_VALID = 1'b1;
    bus.REQ1_ADDR  = 5'd2;
    bus.REQ1_DATA  = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (bus.REQ0_READY !== ((i % 2) == 0)) $display("FAIL b2b_ready0[%0d]: got %b exp %b", i, bus.REQ0_READY, (i % 2) == 0); else n_pass++;
      n_total++; if (bus.REQ1_READY !== ((i % 2) == 1)) $display("FAIL b2b_ready1[%0d]: got %b exp %b", i, bus.REQ1_READY, (i % 2) == 1); else n_pass++;
      tick();
      exp_a = ((i % 2) == 0) ? 5'd1 : 5'd2;
      exp_d = ((i % 2) == 0) ? 32'h11 : 32'h22;
      n_total++; if (bus.WE3 !== 1'b1) $display("FAIL b2b_we3[%0d]: got %b exp 1", i, bus.WE3); else n_pass++;
      n_total++; if (bus.A3 !== exp_a) $display("FAIL b2b_a3[%0d]: got %0d exp %0d", i, bus.A3, exp_a); else n_pass++;
      n_total++; if (bus.WD3 !== exp_d) $display("FAIL b2b_wd3[%0d]: got %h exp %h", i, bus.WD3, exp_d); else n_pass++;
    end
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    tick();
    n_total++; if (bus.WE3 !== 1'b0) $display("FAIL b2b_we3_off: got %b exp 0", bus.WE3); else n_pass++;
  endtask

  task automatic test_req1_addr0();
    bus.REQ1_VALID = 1'b1;
    bus.REQ1_ADDR  = 5'd0;
    bus.REQ1_DATA  = 32'hCAFEF00D;
    #1;
    n_total++; if (bus.REQ1_READY !== 1'b1) $display("FAIL r1_ready1: got %b exp 1", bus.REQ1_READY); else n_pass++;
    n_total++; if (bus.REQ0_READY !== 1'b0) $display("FAIL r1_ready0: got %b exp 0", bus.REQ0_READY); else n_pass++;
    tick();
    bus.REQ1_VALID = 1'b0;
    n_total++; if (bus.WE3 !== 1'b1) $display("FAIL r1_we3: got %b exp 1", bus.WE3); else n_pass++;
    n_total++; if (bus.A3 !== 5'd0) $display("FAIL r1_a3: got %0d exp 0", bus.A3); else n_pass++;
    n_total++; if (bus.WD3 !== 32'hCAFEF00D) $display("FAIL r1_wd3: got %h exp cafef00d", bus.WD3); else n_pass++;
    tick();
  endtask

  task automatic test_clear();
    bus.REQ1_VALID = 1'b1;
    bus.REQ1_ADDR  = 5'd9;
    bus.REQ1_DATA  = 32'h99;
    bus.CLR_START  = 1'b1;
    #1;
    n_total++; if (bus.REQ1_READY !== 1'b0) $display("FAIL clr_stall_ready1: got %b exp 0", bus.REQ1_READY); else n_pass++;
    n_total++; if (bus.REQ0_READY !== 1'b0) $display("FAIL clr_stall_ready0: got %b exp 0", bus.REQ0_READY); else n_pass++;
    tick();
    bus.CLR_START = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      n_total++; if (bus.WE3 !== 1'b1) $display("FAIL clr_we3[%0d]: got %b exp 1", k, bus.WE3); else n_pass++;
      n_total++; if (bus.A3 !== 5'(k - 1)) $display("FAIL clr_a3[%0d]: got %0d exp %0d", k, bus.A3, k - 1); else n_pass++;
      n_total++; if (bus.WD3 !== 32'd0) $display("FAIL clr_wd3[%0d]: got %h exp 0", k, bus.WD3); else n_pass++;
      n_total++; if (bus.BUSY !== 1'b1) $display("FAIL clr_busy[%0d]: got %b exp 1", k, bus.BUSY); else n_pass++;
      n_total++; if (bus.CLR_DONE !== (k == 8)) $display("FAIL clr_done[%0d]: got %b exp %b", k, bus.CLR_DONE, k == 8); else n_pass++;
      n_total++; if (bus.REQ1_READY !== (k == 8)) $display("FAIL clr_ready1[%0d]: got %b exp %b", k, bus.REQ1_READY, k == 8); else n_pass++;
      tick();
    end
    bus.REQ1_VALID = 1'b0;
    n_total++; if (bus.WE3 !== 1'b1) $display("FAIL clr_post_we3: got %b exp 1", bus.WE3); else n_pass++;
    n_total++; if (bus.A3 !== 5'd9) $display("FAIL clr_post_a3: got %0d exp 9", bus.A3); else n_pass++;
    n_total++; if (bus.WD3 !== 32'h99) $display("FAIL clr_post_wd3: got %h exp 99", bus.WD3); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL clr_post_busy: got %b exp 0", bus.BUSY); else n_pass++;
    n_total++; if (bus.CLR_DONE !== 1'b0) $display("FAIL clr_post_done: got %b exp 0", bus.CLR_DONE); else n_pass++;
    tick();
    n_total++; if (bus.WE3 !== 1'b0) $display("FAIL clr_idle_we3: got %b exp 0", bus.WE3); else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    int writes;
    int dones;
    bus.CLR_START = 1'b1;
    tick();
    bus.CLR_START = 1'b0;
    tick();
    tick();
    n_total++; if (bus.A3 !== 5'd2) $display("FAIL rmc_a3_before: got %0d exp 2", bus.A3); else n_pass++;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_total++; if (bus.WE3 !== 1'b0) $display("FAIL rmc_we3: got %b exp 0", bus.WE3); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL rmc_busy: got %b exp 0", bus.BUSY); else n_pass++;
    n_total++; if (bus.CLR_DONE !== 1'b0) $display("FAIL rmc_done: got %b exp 0", bus.CLR_DONE); else n_pass++;
    writes = 0;
    dones  = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.WE3 === 1'b1) writes++;
      if (bus.CLR_DONE === 1'b1) dones++;
    end
    n_total++; if (writes !== 0) $display("FAIL rmc_stray_writes: got %0d exp 0", writes); else n_pass++;
    n_total++; if (dones !== 0) $display("FAIL rmc_stray_done: got %0d exp 0", dones); else n_pass++;
    bus.CLR_START = 1'b1;
    tick();
    bus.CLR_START = 1'b0;
    n_total++; if (bus.WE3 !== 1'b1) $display("FAIL rmc_restart_we3: got %b exp 1", bus.WE3); else n_pass++;
    n_total++; if (bus.A3 !== 5'd0) $display("FAIL rmc_restart_a3: got %0d exp 0", bus.A3); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b1) $display("FAIL rmc_restart_busy: got %b exp 1", bus.BUSY); else n_pass++;
    for (int c = 0; c < 8; c++) tick();
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL rmc_drain_busy: got %b exp 0", bus.BUSY); else n_pass++;
  endtask

  task automatic test_clr_repulse();
    int writes;
    int dones;
    int bad_addr;
    bus.CLR_START = 1'b1;
    tick();
    writes   = 0;
    dones    = 0;
    bad_addr = 0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.WE3 === 1'b1) begin
        if (bus.A3 !== 5'(writes) || bus.WD3 !== 32'd0) bad_addr++;
        writes++;
      end
      if (bus.CLR_DONE === 1'b1) dones++;
      bus.CLR_START = (c == 3) || (c == 8);
      tick();
    end
    bus.CLR_START = 1'b0;
    n_total++; if (writes !== 8) $display("FAIL rep_writes: got %0d exp 8", writes); else n_pass++;
    n_total++; if (dones !== 1) $display("FAIL rep_dones: got %0d exp 1", dones); else n_pass++;
    n_total++; if (bad_addr !== 0) $display("FAIL rep_addr_seq: got %0d bad exp 0", bad_addr); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL rep_busy_end: got %b exp 0", bus.BUSY); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    RESET   = 1'b1;
    idle_inputs();
    test_reset();
    test_single_req0();
    test_back_to_back();
    test_req1_addr0();
    test_clear();
    test_reset_mid_clear();
    test_clr_repulse();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter CLR_COUNT, default 8: number of registers zeroed by a clear sequence, addresses 0..CLR_COUNT-1, legal range 1..32.
REQ-002 SHALL have CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have REQ0_VALID  input  1  requester 0 write request.
REQ-005 SHALL have REQ0_ADDR  input  5  requester 0 destination register.
REQ-006 SHALL have REQ0_DATA  input  32  requester 0 write data.
REQ-007 SHALL have REQ0_READY  output  1  requester 0 accepted this cycle.
REQ-008 SHALL have REQ1_VALID  input  1  requester 1 write request.
REQ-009 SHALL have REQ1_ADDR  input  5  requester 1 destination register.
REQ-010 SHALL have REQ1_DATA  input  32  requester 1 write data.
REQ-011 SHALL have REQ1_READY  output  1  requester 1 accepted this cycle.
REQ-012 SHALL have CLR_START  input  1  request zeroing of registers 0..CLR_COUNT-1.
REQ-013 SHALL have BUSY  output  1  clear sequence in progress.
REQ-014 SHALL have CLR_DONE  output  1  one-cycle pulse on final clear write.
REQ-015 SHALL have WE3  output  1  register file write enable, registered.
REQ-016 SHALL have A3  output  5  register file write address, registered.
REQ-017 SHALL have WD3  output  32  register file write data, registered.

Function
REQ-018 SHALL implement FSM states IDLE and CLEAR, plus a 1-bit round-robin pointer PRIO and a 5-bit clear counter.
REQ-019 SHALL complete a handshake on requester i when REQi_VALID and REQi_READY are both high at a rising edge.
REQ-020 SHALL drive REQi_READY combinationally: high only when RESET=0, state=IDLE, CLR_START=0, REQi_VALID=1, and the other requester is not valid or PRIO=i.
REQ-021 SHALL never assert REQ0_READY and REQ1_READY in the same cycle.
REQ-022 SHALL, after a handshake on requester i at edge N, drive WE3=1, A3=REQi_ADDR, WD3=REQi_DATA for exactly cycle N+1 (latency 1), and set PRIO to the other requester.
REQ-023 SHALL leave PRIO unchanged in cycles with no handshake.
REQ-024 SHALL drive WE3=0 in any cycle not following a handshake and not in CLEAR; A3/WD3 then hold their last values.
REQ-025 SHALL sustain one write per cycle under continuous requests; with both requesters always valid, grants alternate.
REQ-026 SHALL pass all 5 address bits unmodified; address 0 is writable and is not special.
REQ-027 SHALL, when CLR_START=1 at edge N in IDLE, enter CLEAR and drive WE3=1, WD3=0, A3=0,1,...,CLR_COUNT-1 in cycles N+1..N+CLR_COUNT.
REQ-028 SHALL hold BUSY=1 in cycles N+1..N+CLR_COUNT, assert CLR_DONE only in cycle N+CLR_COUNT, and return to IDLE so that BUSY=0 in cycle N+CLR_COUNT+1.
REQ-029 SHALL give CLR_START priority over simultaneous requests; those requests stall (READY=0) and are not lost while VALID stays high.
REQ-030 SHALL ignore CLR_START while BUSY=1.
REQ-031 SHALL accept a request in cycle N+CLR_COUNT (READY may assert then because the FSM returns to IDLE at that edge); that write appears in cycle N+CLR_COUNT+1.
REQ-032 SHALL not change PRIO during a clear sequence.

Reset
REQ-033 SHALL, with RESET=1 at an edge, set state=IDLE, PRIO=0, counter=0, WE3=0, A3=0, WD3=0, BUSY=0, CLR_DONE=0, and hold REQ0_READY=REQ1_READY=0 while RESET=1.
REQ-034 SHALL, on RESET asserted mid-clear, abort without CLR_DONE, issue no further clear writes, and accept CLR_START as a fresh sequence from address 0 after release.

Verification
REQ-035 SHALL be tested: REQ0 valid alone, ADDR=5, DATA=0xDEADBEEF -> READY0 high, next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
REQ-036 SHALL be tested: both valid for 4 cycles after reset (ADDR 1/2, DATA 0x11/0x22) -> grants 0,1,0,1; A3 sequence 1,2,1,2, WE3 high for 4 consecutive cycles.
REQ-037 SHALL be tested: CLR_START with REQ1 valid at edge N, CLR_COUNT=8 -> A3=0..7 with WD3=0 in N+1..N+8, CLR_DONE only in N+8, REQ1 write appears in N+9.
REQ-038 SHALL be tested: RESET pulsed in clear cycle N+3 -> WE3=0, BUSY=0 next cycle, no CLR_DONE; a later CLR_START restarts at A3=0.
REQ-039 SHALL be tested: CLR_START re-pulsed during BUSY -> exactly 8 clear writes, single CLR_DONE.
